// File: rtl/ldpc_iter_ctrl_pkg.sv
// ldpc_iter_ctrl_pkg: shared state encoding and sizing defaults for the LDPC iteration controller
package ldpc_iter_ctrl_pkg;
  localparam int ITER_W_DEF = 6;
  localparam int TMO_W_DEF = 12;
  localparam int MAX_ITER_ZERO_AS = 1;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_CPU  = 3'd2,
    S_VPU  = 3'd3,
    S_CHK  = 3'd4,
    S_OUT  = 3'd5,
    S_DONE = 3'd6
  } state_t;
endpackage

// File: rtl/ldpc_phase_wdog.sv
// ldpc_phase_wdog: per-phase watchdog, expires when the count is about to reach all-ones
module ldpc_phase_wdog #(
  parameter int W = 12
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= clear ? '0 : enable ? cnt + W'(1) : cnt;
  assign expire = enable && cnt == {{(W-1){1'b1}}, 1'b0};
endmodule

// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: sequences init/check-node/variable-node/readout phases of one LDPC codeword
module ldpc_iter_ctrl
  import ldpc_iter_ctrl_pkg::*;
#(
  parameter int ITER_W = ITER_W_DEF,
  parameter int TMO_W  = TMO_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              rate_in,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              init_b,
  input  logic              cpu_b,
  input  logic              vpu_b,
  input  logic              parity_ok,
  input  logic              dec_b,
  output logic              rate,
  output logic              init_a,
  output logic              cpu_a,
  output logic              vpu_a,
  output logic              dec_a,
  output logic              busy,
  output logic              done,
  output logic              early_stop,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_cnt,
  output logic [2:0]        ctrl_state
);
  state_t state, state_nxt;
  logic entry, parity_q, wd_exp, wd_en, accept, kill;
  logic [ITER_W-1:0] max_q, iter_inc;
  assign accept = state == S_IDLE && start && !abort;
  assign kill = state != S_IDLE && abort;
  assign wd_en = state inside {S_INIT, S_CPU, S_VPU, S_OUT};
  assign iter_inc = &iter_cnt ? iter_cnt : iter_cnt + ITER_W'(1);
  always_comb begin
    state_nxt = state;
    if (kill || wd_exp) state_nxt = S_IDLE;
    else
      case (state)
        S_IDLE:  state_nxt = accept ? S_INIT : S_IDLE;
        S_INIT:  state_nxt = init_b ? S_CPU : S_INIT;
        S_CPU:   state_nxt = cpu_b ? S_VPU : S_CPU;
        S_VPU:   state_nxt = vpu_b ? S_CHK : S_VPU;
        S_CHK:   state_nxt = (parity_q || iter_inc == max_q) ? S_OUT : S_CPU;
        S_OUT:   state_nxt = dec_b ? S_DONE : S_OUT;
        default: state_nxt = S_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= S_IDLE;
      entry      <= 1'b0;
      rate       <= 1'b0;
      max_q      <= '0;
      parity_q   <= 1'b0;
      iter_cnt   <= '0;
      early_stop <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state <= state_nxt;
      entry <= state_nxt != state;
      if (accept) begin
        rate       <= rate_in;
        max_q      <= max_iter == '0 ? ITER_W'(MAX_ITER_ZERO_AS) : max_iter;
        parity_q   <= 1'b0;
        iter_cnt   <= '0;
        early_stop <= 1'b0;
        timeout    <= 1'b0;
      end
      if (state == S_VPU && vpu_b) parity_q <= parity_ok;
      if (state == S_CHK && !kill) begin
        iter_cnt   <= iter_inc;
        early_stop <= parity_q;
      end
      if (wd_exp && !kill) timeout <= 1'b1;
    end
  ldpc_phase_wdog #(.W(TMO_W)) u_wdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state_nxt != state),
    .enable (wd_en),
    .expire (wd_exp)
  );
  assign init_a     = entry && state == S_INIT;
  assign cpu_a      = entry && state == S_CPU;
  assign vpu_a      = entry && state == S_VPU;
  assign dec_a      = entry && state == S_OUT;
  assign busy       = state != S_IDLE;
  assign done       = state == S_DONE;
  assign ctrl_state = state;
endmodule
